dma_2d_write_master: RTL

- Write-side counterpart of the 2D DMA read master.
- Drains a first-word-fall-through FIFO and writes a rectangular region (width bytes × height rows, row pitch = stride) to memory over AXI4-Full AW/W/B channels.
- Sits between the DMA data FIFO and the M_AXI write port. The write-channel wrapper instantiates it; that wrapper ties the read channel off.
- One burst outstanding at a time. Done is reported only after the final write response.

---
 rtl/dma_2d_write_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dma_2d_write_master.sv
// 2D DMA write master: drains a FWFT FIFO into a width x height region (row pitch = stride) over AXI4 AW/W/B, one burst in flight.
// AWVALID two cycles after start; W stalls on empty FIFO or WREADY=0; DMA2D_WR_4K_SPLIT_EN keeps bursts inside 4 KB pages.
module dma_2d_write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 256
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          i_start,
  input  logic [31:0]                   i_dst_addr,
  input  logic [31:0]                   i_img_width,
  input  logic [31:0]                   i_img_height,
  input  logic [31:0]                   i_img_stride,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] i_w_data,
  input  logic                          i_fifo_empty,
  output logic                          o_fifo_pop,
  output logic                          o_write_done,
  output logic                          o_busy,
  output logic                          o_bresp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CALC = 3'd1;
  localparam logic [2:0] AW   = 3'd2;
  localparam logic [2:0] W    = 3'd3;
  localparam logic [2:0] B    = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [8:0] MAX_LEN = 9'(C_M_AXI_BURST_LEN);

  logic [2:0]                    state;
  logic [29:0]                   row_beats;
  logic [29:0]                   row_left;
  logic [31:0]                   rows_left;
  logic [31:0]                   stride;
  logic [31:0]                   row_addr;
  logic [31:0]                   cur_addr;
  logic [8:0]                    len;
  logic [7:0]                    beat_cnt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                    awlen;
  logic                          bresp_err;

  logic [8:0]  len_calc;
  logic [29:0] row_left_nxt;
  logic        w_hs;
  logic        last_beat;
  logic        unused_lsbs;

  // Word alignment is forced, so the byte-offset bits of these inputs never matter.
  assign unused_lsbs = ^{i_dst_addr[1:0], i_img_width[1:0], i_img_stride[1:0]};

`ifdef DMA2D_WR_4K_SPLIT_EN
  logic [10:0] room_beats;
`endif

  always_comb begin
    len_calc = (row_left > {21'd0, MAX_LEN}) ? MAX_LEN : row_left[8:0];
`ifdef DMA2D_WR_4K_SPLIT_EN
    // Beats remaining before the next 4 KB page boundary (1..1024).
    room_beats = 11'd1024 - {1'b0, cur_addr[11:2]};
    if ({2'b00, len_calc} > room_beats) len_calc = room_beats[8:0];
`endif
  end

  assign row_left_nxt = row_left - {21'd0, len};
  assign last_beat    = ({1'b0, beat_cnt} == (len - 9'd1));
  assign w_hs         = M_AXI_WVALID & M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= IDLE;
      row_beats <= '0;
      row_left  <= '0;
      rows_left <= '0;
      stride    <= '0;
      row_addr  <= '0;
      cur_addr  <= '0;
      len       <= '0;
      beat_cnt  <= '0;
      awaddr    <= '0;
      awlen     <= '0;
      bresp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            row_beats <= i_img_width[31:2];
            row_left  <= i_img_width[31:2];
            rows_left <= i_img_height;
            stride    <= {i_img_stride[31:2], 2'b00};
            row_addr  <= {i_dst_addr[31:2], 2'b00};
            cur_addr  <= {i_dst_addr[31:2], 2'b00};
            bresp_err <= 1'b0;
            state     <= ((i_img_width[31:2] == 30'd0) || (i_img_height == 32'd0)) ? DONE : CALC;
          end
        end
        CALC: begin
          len      <= len_calc;
          awaddr   <= C_M_AXI_ADDR_WIDTH'(cur_addr);
          awlen    <= 8'(len_calc - 9'd1);
          beat_cnt <= '0;
          state    <= AW;
        end
        AW: begin
          if (M_AXI_AWREADY) state <= W;
        end
        W: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= B;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        B: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) bresp_err <= 1'b1;
            if (row_left_nxt != 30'd0) begin
              cur_addr <= cur_addr + {21'd0, len, 2'b00};
              row_left <= row_left_nxt;
              state    <= CALC;
            end else if (rows_left > 32'd1) begin
              rows_left <= rows_left - 32'd1;
              row_addr  <= row_addr + stride;
              cur_addr  <= row_addr + stride;
              row_left  <= row_beats;
              state     <= CALC;
            end else begin
              cur_addr <= cur_addr + {21'd0, len, 2'b00};
              row_left <= row_left_nxt;
              state    <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign M_AXI_AWADDR  = awaddr;
  assign M_AXI_AWLEN   = awlen;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (state == AW);
  assign M_AXI_WVALID  = (state == W) & ~i_fifo_empty;
  // FIFO head passes straight through; zeroed outside W so idle/reset output is clean.
  assign M_AXI_WDATA   = (state == W) ? i_w_data : '0;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WLAST   = (state == W) & last_beat;
  assign M_AXI_BREADY  = (state == B);

  assign o_fifo_pop   = w_hs;
  assign o_write_done = (state == DONE);
  assign o_busy       = (state == CALC) || (state == AW) || (state == W) || (state == B);
  assign o_bresp_err  = bresp_err;

endmodule
